// File: rtl/alu_seq_controller_if.sv
// rtl/alu_seq_controller_if.sv - instruction/result bundle for the ALU sequencing controller
//
// Groups the instruction fields and the controller responses into one bundle.
//   master : drives valid_in/opcode/funct/src_a/src_b, observes the responses
//   slave  : the controller; drives alu_cmd_out, stall_out, busy, done,
//            div_by_zero, result, result_valid
interface alu_seq_controller_if #(
    parameter int WIDTH = 32
) ();
    logic             valid_in;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [2:0]       alu_cmd_out;
    logic             stall_out;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] result;
    logic             result_valid;

    modport master (
        output valid_in, opcode, funct, src_a, src_b,
        input  alu_cmd_out, stall_out, busy, done, div_by_zero, result, result_valid
    );

    modport slave (
        input  valid_in, opcode, funct, src_a, src_b,
        output alu_cmd_out, stall_out, busy, done, div_by_zero, result, result_valid
    );
endinterface

// File: rtl/alu_seq_controller.sv
// rtl/alu_seq_controller.sv - ALU command decode plus iterative multiply/divide HI/LO unit
//
// Decodes single-cycle ALU commands combinationally and runs a multi-cycle
// radix-2 multiply / restoring divide for mult/multu/div/divu, writing HI/LO.
// mfhi/mflo read HI/LO into a registered result.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_seq_controller_if.slave (instruction in, responses out)
module alu_seq_controller #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_seq_controller_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [5:0] F_ADD   = 6'b10_0000;
    localparam logic [5:0] F_SUB   = 6'b10_0010;
    localparam logic [5:0] F_AND   = 6'b10_0100;
    localparam logic [5:0] F_OR    = 6'b10_0101;
    localparam logic [5:0] F_SLT   = 6'b10_1010;
    localparam logic [5:0] F_MULT  = 6'b01_1000;
    localparam logic [5:0] F_MULTU = 6'b01_1001;
    localparam logic [5:0] F_DIV   = 6'b01_1010;
    localparam logic [5:0] F_DIVU  = 6'b01_1011;
    localparam logic [5:0] F_MFHI  = 6'b01_0000;
    localparam logic [5:0] F_MFLO  = 6'b01_0010;

    localparam logic [5:0] OP_ADDI = 6'b00_1000;
    localparam logic [5:0] OP_ANDI = 6'b00_1100;
    localparam logic [5:0] OP_ORI  = 6'b00_1101;
    localparam logic [5:0] OP_SLTI = 6'b00_1010;

    localparam logic [2:0] CMD_NONE = 3'd0;
    localparam logic [2:0] CMD_ADD  = 3'd1;
    localparam logic [2:0] CMD_SUB  = 3'd2;
    localparam logic [2:0] CMD_AND  = 3'd3;
    localparam logic [2:0] CMD_OR   = 3'd4;
    localparam logic [2:0] CMD_SLT  = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // hw/lw: multiply = {partial product, multiplier}; divide = {remainder, dividend}
    logic [WIDTH-1:0] hw_q, hw_d;
    logic [WIDTH-1:0] lw_q, lw_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             is_div_q, is_div_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic             done_q, done_d;
    logic             dz_pulse_q, dz_pulse_d;

    logic [2:0]       alu_cmd;
    logic             is_mul, is_dv, is_mf, is_hilo;
    logic             busy, accept;
    logic             signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh, div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    // Single-cycle ALU decode; independent of busy and valid_in.
    always_comb begin
        alu_cmd = CMD_NONE;
        if (bus.opcode == 6'd0) begin
            case (bus.funct)
                F_ADD:   alu_cmd = CMD_ADD;
                F_SUB:   alu_cmd = CMD_SUB;
                F_AND:   alu_cmd = CMD_AND;
                F_OR:    alu_cmd = CMD_OR;
                F_SLT:   alu_cmd = CMD_SLT;
                default: alu_cmd = CMD_NONE;
            endcase
        end else begin
            case (bus.opcode)
                OP_ADDI: alu_cmd = CMD_ADD;
                OP_ANDI: alu_cmd = CMD_AND;
                OP_ORI:  alu_cmd = CMD_OR;
                OP_SLTI: alu_cmd = CMD_SLT;
                default: alu_cmd = CMD_NONE;
            endcase
        end
    end

    always_comb begin
        is_mul  = (bus.opcode == 6'd0) && (bus.funct == F_MULT || bus.funct == F_MULTU);
        is_dv   = (bus.opcode == 6'd0) && (bus.funct == F_DIV  || bus.funct == F_DIVU);
        is_mf   = (bus.opcode == 6'd0) && (bus.funct == F_MFHI || bus.funct == F_MFLO);
        is_hilo = is_mul | is_dv | is_mf;
        busy    = (state_q != S_IDLE);
        accept  = bus.valid_in & ~busy & is_hilo;
        // funct[0] clear selects the signed variant of mult/div.
        signed_op = ~bus.funct[0];
        a_neg     = signed_op & bus.src_a[WIDTH-1];
        b_neg     = signed_op & bus.src_b[WIDTH-1];
        mag_a     = a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
        mag_b     = b_neg ? (~bus.src_b + 1'b1) : bus.src_b;
    end

    // Iteration datapath and final sign correction.
    always_comb begin
        mul_sum  = {1'b0, hw_q} + {1'b0, (lw_q[0] ? opb_q : {WIDTH{1'b0}})};
        div_sh   = {hw_q, lw_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, opb_q};
        prod     = {hw_q, lw_q};
        prod_fix = neg_lo_q ? (~prod + 1'b1) : prod;
        quo_fix  = neg_lo_q ? (~lw_q + 1'b1) : lw_q;
        rem_fix  = neg_hi_q ? (~hw_q + 1'b1) : hw_q;
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        hw_d           = hw_q;
        lw_d           = lw_q;
        opb_d          = opb_q;
        neg_lo_d       = neg_lo_q;
        neg_hi_d       = neg_hi_q;
        is_div_d       = is_div_q;
        dz_d           = dz_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        done_d         = 1'b0;
        dz_pulse_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept && (is_mul || is_dv)) begin
                    state_d  = is_mul ? S_MUL : S_DIV;
                    cnt_d    = CW'(WIDTH);
                    hw_d     = {WIDTH{1'b0}};
                    lw_d     = mag_a;
                    opb_d    = mag_b;
                    neg_lo_d = a_neg ^ b_neg;
                    // Remainder follows the dividend's sign.
                    neg_hi_d = is_dv & a_neg;
                    is_div_d = is_dv;
                    dz_d     = is_dv && (bus.src_b == {WIDTH{1'b0}});
                end
                if (accept && is_mf) begin
                    result_d       = (bus.funct == F_MFHI) ? hi_q : lo_q;
                    result_valid_d = 1'b1;
                end
            end
            S_MUL: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = S_FIN;
                end else begin
                    hw_d  = mul_sum[WIDTH:1];
                    lw_d  = {mul_sum[0], lw_q[WIDTH-1:1]};
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DIV: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = S_FIN;
                end else begin
                    // Restoring step: keep the difference only if it did not go negative.
                    if (!div_diff[WIDTH]) begin
                        hw_d = div_diff[WIDTH-1:0];
                        lw_d = {lw_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hw_d = div_sh[WIDTH-1:0];
                        lw_d = {lw_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    // With a zero divisor the remainder register ends up holding |src_a|,
                    // so sign restoration already yields src_a; only LO needs forcing.
                    hi_d       = rem_fix;
                    lo_d       = dz_q ? {WIDTH{1'b1}} : quo_fix;
                    dz_pulse_d = dz_q;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= {CW{1'b0}};
            hw_q           <= {WIDTH{1'b0}};
            lw_q           <= {WIDTH{1'b0}};
            opb_q          <= {WIDTH{1'b0}};
            neg_lo_q       <= 1'b0;
            neg_hi_q       <= 1'b0;
            is_div_q       <= 1'b0;
            dz_q           <= 1'b0;
            hi_q           <= {WIDTH{1'b0}};
            lo_q           <= {WIDTH{1'b0}};
            result_q       <= {WIDTH{1'b0}};
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
            dz_pulse_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            hw_q           <= hw_d;
            lw_q           <= lw_d;
            opb_q          <= opb_d;
            neg_lo_q       <= neg_lo_d;
            neg_hi_q       <= neg_hi_d;
            is_div_q       <= is_div_d;
            dz_q           <= dz_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            done_q         <= done_d;
            dz_pulse_q     <= dz_pulse_d;
        end
    end

    assign bus.alu_cmd_out  = alu_cmd;
    assign bus.stall_out    = bus.valid_in & busy & is_hilo;
    assign bus.busy         = busy;
    assign bus.done         = done_q;
    assign bus.div_by_zero  = dz_pulse_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
endmodule
